// File: rtl/trap_unit.sv
// Machine-mode trap/return sequencer: maintains mstatus/mtvec/mepc/mcause.
// It issues a registered one-cycle redirect+flush in the cycle after a trap or an accepted mret.
module trap_unit #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      int_cause,
   input  logic            mret,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            mie_o
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   typedef enum logic {IDLE, REDIR} state_t;

   state_t          state;
   logic            mie;
   logic            mpie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;

   logic            idle_valid;
   logic            take_irq;
   logic            take_ill;
   logic            take_ecall;
   logic            trap;
   logic            take_mret;
   logic            event_any;
   logic [XLEN-1:0] tvec_base;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] cause_val;

   // Interrupt only traps when enabled; otherwise the instruction proceeds untouched.
   assign idle_valid = (state == IDLE) && valid;
   assign take_irq   = idle_valid && (int_cause == 2'd3) && mie;
   assign take_ill   = idle_valid && (int_cause == 2'd1);
   assign take_ecall = idle_valid && (int_cause == 2'd2);
   assign trap       = take_irq || take_ill || take_ecall;
   assign take_mret  = idle_valid && mret && !trap;
   assign event_any  = trap || take_mret;

   assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
   assign trap_pc   = (take_irq && (mtvec[1:0] == 2'b01)) ? tvec_base + XLEN'(44) : tvec_base;

   always_comb begin
      cause_val = XLEN'(32'h0000_000B);
      if (take_irq)
         cause_val = XLEN'(32'h8000_000B);
      else if (take_ill)
         cause_val = XLEN'(32'h0000_0002);
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         ADDR_MSTATUS: begin
            csr_rdata[3] = mie;
            csr_rdata[7] = mpie;
         end
         ADDR_MTVEC:  csr_rdata = mtvec;
         ADDR_MEPC:   csr_rdata = mepc;
         ADDR_MCAUSE: csr_rdata = mcause;
         default:     csr_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         redirect    <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         mie         <= 1'b0;
         mpie        <= 1'b0;
         mtvec       <= MTVEC_RESET;
         mepc        <= '0;
         mcause      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (event_any) begin
                  state       <= REDIR;
                  redirect    <= 1'b1;
                  flush       <= 1'b1;
                  redirect_pc <= trap ? trap_pc : mepc;
               end
            end
            REDIR: begin
               state    <= IDLE;
               redirect <= 1'b0;
               flush    <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               redirect <= 1'b0;
               flush    <= 1'b0;
            end
         endcase

         // Trap/mret own mstatus/mepc/mcause this cycle; mtvec writes always land.
         if (csr_we) begin
            case (csr_addr)
               ADDR_MTVEC: mtvec <= csr_wdata;
               ADDR_MSTATUS: if (!event_any) begin
                  mie  <= csr_wdata[3];
                  mpie <= csr_wdata[7];
               end
               ADDR_MEPC: if (!event_any)
                  mepc <= {csr_wdata[XLEN-1:2], 2'b00};
               ADDR_MCAUSE: if (!event_any)
                  mcause <= csr_wdata;
               default: ;
            endcase
         end

         if (trap) begin
            mepc   <= pc;
            mcause <= cause_val;
            mpie   <= mie;
            mie    <= 1'b0;
         end else if (take_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
         end
      end
   end

   assign mie_o = mie;

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed scenarios plus random traffic against a rule-level reference model.
module tb_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] pc;
   logic [1:0]  int_cause;
   logic        mret;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        mie_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state, updated from the architectural rules.
   bit          m_mie, m_mpie, m_red;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc;

   localparam logic [31:0] RST_TVEC = 32'h0000_0000;

   trap_unit #(.XLEN(32), .MTVEC_RESET(RST_TVEC)) dut (
      .clk(clk), .rst(rst), .valid(valid), .pc(pc), .int_cause(int_cause),
      .mret(mret), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .mie_o(mie_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   // One clock: drive inputs, let the edge happen, advance the model, check outputs.
   task automatic cyc(input bit r, input bit v, input logic [31:0] p, input logic [1:0] c,
                      input bit m, input bit w, input logic [11:0] a, input logic [31:0] d);
      bit          ev, is_trap;
      logic [31:0] tgt, cause, base;
      rst = r; valid = v; pc = p; int_cause = c; mret = m;
      csr_we = w; csr_addr = a; csr_wdata = d;
      @(posedge clk);
      if (r) begin
         m_mie = 0; m_mpie = 0; m_red = 0; m_rpc = 0;
         m_mtvec = RST_TVEC; m_mepc = 0; m_mcause = 0;
      end else begin
         ev = 0; is_trap = 0; tgt = 0; cause = 0;
         base = m_mtvec & ~32'd3;
         if (!m_red && v) begin
            if (c == 2'd3 && m_mie) begin
               is_trap = 1; cause = 32'h8000_000B;
               tgt = (m_mtvec[1:0] == 2'b01) ? base + 32'd44 : base;
            end else if (c == 2'd1) begin
               is_trap = 1; cause = 32'h2; tgt = base;
            end else if (c == 2'd2) begin
               is_trap = 1; cause = 32'hB; tgt = base;
            end
            ev = is_trap || m;
            if (!is_trap && m) tgt = m_mepc;
         end
         if (w) begin
            if (a == 12'h305) m_mtvec = d;
            if (!ev) begin
               if (a == 12'h300) begin m_mie = d[3]; m_mpie = d[7]; end
               if (a == 12'h341) m_mepc = d & ~32'd3;
               if (a == 12'h342) m_mcause = d;
            end
         end
         if (is_trap) begin
            m_mepc = p; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
         end else if (ev) begin
            m_mie = m_mpie; m_mpie = 1;
         end
         m_red = ev;
         if (ev) m_rpc = tgt;
      end
      #1;
      check("redirect", {31'b0, redirect}, {31'b0, m_red});
      check("flush", {31'b0, flush}, {31'b0, m_red});
      if (m_red) check("redirect_pc", redirect_pc, m_rpc);
      check("mie_o", {31'b0, mie_o}, {31'b0, m_mie});
      check("csr_rdata", csr_rdata, m_read(a));
   endtask

   task automatic idle(input logic [11:0] a);
      cyc(0, 0, 32'h0, 2'd0, 0, 0, a, 32'h0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc(0, 0, 32'h0, 2'd0, 0, 1, a, d);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 12'h300, 0);
      check("rst_mstatus", csr_rdata, 32'h0);
      check("rst_redirect", {31'b0, redirect}, 32'h0);
      idle(12'h305); check("rst_mtvec", csr_rdata, RST_TVEC);
      idle(12'h341); check("rst_mepc", csr_rdata, 32'h0);
      idle(12'h342); check("rst_mcause", csr_rdata, 32'h0);

      // Ecall to a direct vector
      wr(12'h305, 32'h100);
      cyc(0, 1, 32'h40, 2'd2, 0, 0, 12'h341, 0);
      check("ecall_rpc", redirect_pc, 32'h100);
      check("ecall_mepc", csr_rdata, 32'h40);
      idle(12'h342);
      check("ecall_mcause", csr_rdata, 32'hB);
      check("ecall_pulse_end", {31'b0, redirect}, 32'h0);

      // Vectored interrupt then mret
      wr(12'h300, 32'h8);
      wr(12'h305, 32'h101);
      cyc(0, 1, 32'h80, 2'd3, 0, 0, 12'h342, 0);
      check("irq_rpc", redirect_pc, 32'h12C);
      check("irq_mcause", csr_rdata, 32'h8000_000B);
      idle(12'h300);
      check("irq_mstatus", csr_rdata, 32'h80);
      cyc(0, 1, 32'h90, 2'd0, 1, 0, 12'h300, 0);
      check("mret_rpc", redirect_pc, 32'h80);
      check("mret_mstatus", csr_rdata, 32'h88);
      idle(12'h300);

      // Masked interrupt and invalid illegal produce nothing
      wr(12'h300, 32'h0);
      cyc(0, 1, 32'h44, 2'd3, 0, 0, 12'h342, 0);
      check("masked_irq", {31'b0, redirect}, 32'h0);
      cyc(0, 0, 32'h48, 2'd1, 0, 0, 12'h341, 0);
      check("invalid_ill", {31'b0, redirect}, 32'h0);

      // Back-to-back illegals: one pulse, first pc kept
      cyc(0, 1, 32'h200, 2'd1, 0, 0, 12'h341, 0);
      cyc(0, 1, 32'h204, 2'd1, 0, 0, 12'h341, 0);
      check("b2b_second", {31'b0, redirect}, 32'h0);
      check("b2b_mepc", csr_rdata, 32'h200);
      idle(12'h342);

      // Reset while in REDIR drops the pulse
      cyc(0, 1, 32'h300, 2'd2, 0, 0, 12'h341, 0);
      cyc(1, 0, 0, 2'd0, 0, 0, 12'h341, 0);
      check("rst_redir", {31'b0, redirect}, 32'h0);
      check("rst_redir_mepc", csr_rdata, 32'h0);
      idle(12'h305);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] a;
         logic [31:0] d;
         case ($urandom_range(0, 4))
            0: a = 12'h300;
            1: a = 12'h305;
            2: a = 12'h341;
            3: a = 12'h342;
            default: a = 12'h7C0;
         endcase
         d = $urandom;
         if ($urandom_range(0, 1) == 0 && a == 12'h305) d[1:0] = 2'b01;
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
